// File: rtl/neuron_mac_accum.sv
// ============================================================================
// neuron_mac_accum : FP multiply-accumulate front end for sigmoid_approx.
// Optional macro NEURON_MAC_BIAS_EN seeds the accumulator with bias.
// Revision: 1.0
// ============================================================================
`default_nettype none

module neuron_mac_accum #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 24,
  parameter int NUM_INPUTS = 4,
  parameter int CNT_WIDTH  = 8,
  localparam int W = EXP_WIDTH + MANT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   round_mode,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_w,
  input  logic [W-1:0] bias,
  output logic [W-1:0] x_out,
  input  logic [W-1:0] act_in,
  input  logic         act_valid,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         busy
);

  localparam int EW = EXP_WIDTH;
  localparam int MW = MANT_WIDTH;
  localparam int FW = MANT_WIDTH - 1;
  localparam logic signed [EW+1:0] EMAX_S = (EW+2)'((1 << EW) - 1);
  localparam logic signed [EW+1:0] BIAS_S = (EW+2)'((1 << (EW - 1)) - 1);
  localparam logic signed [EW+1:0] ONE_S  = (EW+2)'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
  localparam logic [W-1:0] HALF = {1'b0, EW'((1 << (EW - 1)) - 2), {FW{1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(NUM_INPUTS - 1);

  // m = {significand (hidden bit first), guard, round, sticky}
  function automatic logic [W-1:0] fp_round(input logic s, input logic signed [EW+1:0] e,
                                            input logic [MW+2:0] m, input logic [2:0] rm);
    logic inc;
    logic [MW:0] sig;
    logic signed [EW+1:0] en;
    case (rm)
      3'd0:    inc = m[2] & (m[3] | (|m[1:0]));
      3'd1:    inc = 1'b0;
      3'd2:    inc = s & (|m[2:0]);
      3'd3:    inc = ~s & (|m[2:0]);
      default: inc = m[2];
    endcase
    sig = {1'b0, m[MW+2:3]} + {{MW{1'b0}}, inc};
    en  = e;
    if (sig[MW]) begin
      sig = sig >> 1;
      en  = e + ONE_S;
    end
    if (en >= EMAX_S) return {s, {EW{1'b1}}, {FW{1'b0}}};
    else if (en[EW+1] || en == '0 || !(sig[MW] | sig[MW-1])) return {s, {(W-1){1'b0}}};
    else return {s, en[EW-1:0], sig[FW-1:0]};
  endfunction

  function automatic logic [W-1:0] fp_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] rm);
    logic s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [EW-1:0] ea, eb;
    logic [2*MW-1:0] p;
    logic signed [EW+1:0] e;
    s  = a[W-1] ^ b[W-1];
    ea = a[W-2:FW];
    eb = b[W-2:FW];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (&ea) && (a[FW-1:0] == '0);
    b_inf  = (&eb) && (b[FW-1:0] == '0);
    a_nan  = (&ea) && (|a[FW-1:0]);
    b_nan  = (&eb) && (|b[FW-1:0]);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return QNAN;
    if (a_inf || b_inf) return {s, {EW{1'b1}}, {FW{1'b0}}};
    if (a_zero || b_zero) return {s, {(W-1){1'b0}}};
    p = {{MW{1'b0}}, 1'b1, a[FW-1:0]} * {{MW{1'b0}}, 1'b1, b[FW-1:0]};
    e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
    if (p[2*MW-1]) e = e + ONE_S;
    else           p = p << 1;
    return fp_round(s, e, {p[2*MW-1:MW-2], |p[MW-3:0]}, rm);
  endfunction

  function automatic logic [W-1:0] fp_add(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                                          input logic [2:0] rm);
    logic [W-1:0] a, b;
    logic [EW-1:0] ea, eb, d;
    logic [MW+2:0] ma, mb, mb_sh, mask;
    logic [MW+3:0] sum;
    logic signed [EW+1:0] e;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    int lz;
    a_zero = (a_in[W-2:FW] == '0);
    b_zero = (b_in[W-2:FW] == '0);
    a_inf  = (&a_in[W-2:FW]) && (a_in[FW-1:0] == '0);
    b_inf  = (&b_in[W-2:FW]) && (b_in[FW-1:0] == '0);
    a_nan  = (&a_in[W-2:FW]) && (|a_in[FW-1:0]);
    b_nan  = (&b_in[W-2:FW]) && (|b_in[FW-1:0]);
    if (a_nan || b_nan || (a_inf && b_inf && (a_in[W-1] != b_in[W-1]))) return QNAN;
    if (a_inf) return a_in;
    if (b_inf) return b_in;
    if (a_zero && b_zero)
      return {(a_in[W-1] & b_in[W-1]) | ((a_in[W-1] ^ b_in[W-1]) & (rm == 3'd2)), {(W-1){1'b0}}};
    if (a_zero) return b_in;
    if (b_zero) return a_in;
    // Larger magnitude first so the difference is never negative
    if (a_in[W-2:0] >= b_in[W-2:0]) begin
      a = a_in; b = b_in;
    end else begin
      a = b_in; b = a_in;
    end
    ea    = a[W-2:FW];
    eb    = b[W-2:FW];
    d     = ea - eb;
    ma    = {1'b1, a[FW-1:0], 3'b000};
    mb    = {1'b1, b[FW-1:0], 3'b000};
    mask  = ~({(MW+3){1'b1}} << d);
    mb_sh = (mb >> d) | {{(MW+2){1'b0}}, |(mb & mask)};
    sum   = (a[W-1] == b[W-1]) ? ({1'b0, ma} + {1'b0, mb_sh}) : ({1'b0, ma} - {1'b0, mb_sh});
    if (sum == '0) return {(rm == 3'd2), {(W-1){1'b0}}};
    e = $signed({2'b00, ea});
    if (sum[MW+3]) return fp_round(a[W-1], e + ONE_S, {sum[MW+3:2], |sum[1:0]}, rm);
    lz = 0;
    for (int i = 0; i <= MW + 2; i++) if (sum[i]) lz = MW + 2 - i;
    sum = sum << lz;
    e   = e - (EW+2)'(lz);
    return fp_round(a[W-1], e, sum[MW+2:0], rm);
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_LOAD, S_WAIT} state_t;

  state_t state_q, state_d;
  logic [W-1:0] acc_q, acc_d, x_out_q, x_out_d, result_q, result_d;
  logic [W-1:0] last_x_q, last_x_d, last_act_q, last_act_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic result_valid_q, result_valid_d, armed_q, armed_d;
  logic [W-1:0] prod, acc_sum;

`ifndef NEURON_MAC_BIAS_EN
  logic unused_bias;
  assign unused_bias = ^bias;
`endif

  assign prod    = fp_mul(in_a, in_w, round_mode);
  assign acc_sum = fp_add(acc_q, prod, round_mode);

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    x_out_d        = x_out_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    armed_d        = armed_q;
    last_x_d       = last_x_q;
    last_act_d     = last_act_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef NEURON_MAC_BIAS_EN
          acc_d = bias;
`else
          acc_d = '0;
`endif
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        x_out_d = acc_q;
        // The sigmoid only restarts on a changed input, so a repeat is served from cache
        if (acc_q == last_x_q) begin
          result_d       = last_act_q;
          result_valid_d = 1'b1;
          state_d        = S_IDLE;
        end else begin
          armed_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      default: begin
        if (!armed_q) begin
          armed_d = 1'b1;
        end else if (act_valid) begin
          result_d       = act_in;
          last_x_d       = x_out_q;
          last_act_d     = act_in;
          result_valid_d = 1'b1;
          state_d        = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      acc_q          <= '0;
      cnt_q          <= '0;
      x_out_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      armed_q        <= 1'b0;
      last_x_q       <= '0;
      last_act_q     <= HALF;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      x_out_q        <= x_out_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      armed_q        <= armed_d;
      last_x_q       <= last_x_d;
      last_act_q     <= last_act_d;
    end
  end

  assign in_ready     = (state_q == S_ACCUM);
  assign busy         = (state_q != S_IDLE);
  assign x_out        = x_out_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_neuron_mac_accum.sv
// ============================================================================
// tb_neuron_mac_accum : table vectors, randomized evaluations, reset corners.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_neuron_mac_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  round_mode;
  logic        start, in_valid, in_ready, act_valid, result_valid, busy;
  logic [31:0] in_a, in_w, bias, x_out, act_in, result;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] m_last_x, m_last_act, m_prev_x;

  typedef struct packed {
    logic [3:0][31:0] a;
    logic [3:0][31:0] w;
    logic [3:0]       bub;
    logic [31:0]      act;
    logic             stale;
    logic [31:0]      ex_x;
  } vec_t;

  vec_t tbl[5];

  neuron_mac_accum dut (
    .clk(clk), .rst(rst), .round_mode(round_mode), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_w(in_w),
    .bias(bias), .x_out(x_out), .act_in(act_in), .act_valid(act_valid),
    .result(result), .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] to_f32(input real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  // One full evaluation; the expected sum comes from the caller, the cache from the model
  task automatic run_eval(input logic [3:0][31:0] a, input logic [3:0][31:0] w,
                          input logic [3:0] bub, input logic [31:0] act,
                          input logic stale, input int dly, input logic [31:0] ex_x);
    logic hit;
    hit = (ex_x == m_last_x);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_accum", {31'b0, busy}, 32'd1);
    chk("in_ready_accum", {31'b0, in_ready}, 32'd1);
    chk("x_hold_accum", x_out, m_prev_x);
    for (int i = 0; i < 4; i++) begin
      if (bub[i]) begin
        in_valid = 1'b0; in_a = $urandom; in_w = $urandom;
        step();
        chk("in_ready_bubble", {31'b0, in_ready}, 32'd1);
      end
      in_valid = 1'b1; in_a = a[i]; in_w = w[i];
      step();
    end
    in_valid = 1'b0;
    chk("in_ready_load", {31'b0, in_ready}, 32'd0);
    chk("rv_load", {31'b0, result_valid}, 32'd0);
    step();
    chk("x_out", x_out, ex_x);
    if (hit) begin
      chk("rv_hit", {31'b0, result_valid}, 32'd1);
      chk("result_hit", result, m_last_act);
      chk("busy_hit", {31'b0, busy}, 32'd0);
    end else begin
      chk("rv_wait0", {31'b0, result_valid}, 32'd0);
      chk("busy_wait", {31'b0, busy}, 32'd1);
      if (stale) begin
        act_valid = 1'b1; act_in = ~act;
      end
      step();
      act_valid = 1'b0;
      for (int k = 0; k < dly; k++) begin
        chk("rv_wait", {31'b0, result_valid}, 32'd0);
        chk("x_stable", x_out, ex_x);
        step();
      end
      act_valid = 1'b1; act_in = act;
      step();
      act_valid = 1'b0; act_in = $urandom;
      chk("rv_act", {31'b0, result_valid}, 32'd1);
      chk("result_act", result, act);
      chk("busy_done", {31'b0, busy}, 32'd0);
      m_last_x   = ex_x;
      m_last_act = act;
    end
    m_prev_x = ex_x;
    step();
    chk("rv_pulse_end", {31'b0, result_valid}, 32'd0);
    chk("x_idle", x_out, ex_x);
  endtask

  initial begin
    logic [3:0][31:0] ra, rw;
    real s;
    int ka, kw;

    rst = 1'b1; round_mode = 3'd0; start = 1'b0; in_valid = 1'b0;
    in_a = '0; in_w = '0; bias = 32'h3f800000; act_in = '0; act_valid = 1'b0;
    m_last_x = 32'h0; m_last_act = 32'h3f000000; m_prev_x = 32'h0;

    // all-zero sum hits the reset cache (0 -> 0.5)
    tbl[0] = '{a: '0, w: '0, bub: 4'b0000, act: 32'h12345678, stale: 1'b0, ex_x: 32'h0};
    tbl[1] = '{a: {32'h40800000, 32'h40400000, 32'h40000000, 32'h3f800000},
               w: {4{32'h3f000000}}, bub: 4'b0000, act: 32'h3f7ee8b5, stale: 1'b0,
               ex_x: 32'h40a00000};
    tbl[2] = tbl[1];
    tbl[2].act = 32'hdeadbeef;
    // 2 - 2 - 2 + 1.5 = -0.5, with bubbles and a stale act_valid in the first WAIT cycle
    tbl[3] = '{a: {32'h40400000, 32'h3f800000, 32'hbf800000, 32'h40000000},
               w: {32'h3f000000, 32'hc0000000, 32'h40000000, 32'h3f800000},
               bub: 4'b1010, act: 32'h3e9e0000, stale: 1'b1, ex_x: 32'hbf000000};
    tbl[4] = '{a: {4{32'h3fc00000}}, w: {4{32'h40800000}}, bub: 4'b0101,
               act: 32'h3f7fffe0, stale: 1'b1, ex_x: 32'h41c00000};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_x_out", x_out, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_rv", {31'b0, result_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_busy", {31'b0, busy}, 32'd0);

    for (int t = 0; t < 5; t++)
      run_eval(tbl[t].a, tbl[t].w, tbl[t].bub, tbl[t].act, tbl[t].stale, 10, tbl[t].ex_x);

    // Exactly representable operands keep the real-valued model bit-exact
    ra = '0; rw = '0;
    for (int r = 0; r < 24; r++) begin
      if (r == 0 || $urandom_range(0, 1) == 0) begin
        s = 0.0;
        for (int i = 0; i < 4; i++) begin
          ka = int'($urandom_range(0, 16)) - 8;
          kw = int'($urandom_range(0, 8)) - 4;
          ra[i] = to_f32(ka / 2.0);
          rw[i] = to_f32(kw / 2.0);
          s += (ka * kw) / 4.0;
        end
      end
      case ($urandom_range(0, 3))
        0: round_mode = 3'd0;
        1: round_mode = 3'd1;
        2: round_mode = 3'd3;
        default: round_mode = 3'd4;
      endcase
      run_eval(ra, rw, 4'($urandom), $urandom, 1'($urandom), int'($urandom_range(0, 5)), to_f32(s));
    end
    round_mode = 3'd0;

    // Reset in the middle of WAIT clears everything, including the cache
    ra = '0; rw = '0;
    ra[0] = 32'h41200000; rw[0] = 32'h41200000;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = ra[i]; in_w = rw[i];
      step();
    end
    in_valid = 1'b0;
    step();
    chk("mid_x_out", x_out, 32'h42c80000);
    step(); step();
    chk("mid_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1; act_valid = 1'b1; act_in = 32'h11111111;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_x_out", x_out, 32'h0);
    chk("arst_result", result, 32'h0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    step();
    act_valid = 1'b0;
    chk("post_rst_rv", {31'b0, result_valid}, 32'd0);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    m_last_x = 32'h0; m_last_act = 32'h3f000000; m_prev_x = 32'h0;
    run_eval(tbl[0].a, tbl[0].w, 4'b0011, 32'h0badf00d, 1'b0, 3, 32'h0);
    run_eval(ra, rw, 4'b0000, 32'h3f7fffff, 1'b1, 4, 32'h42c80000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected summary");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/neuron_mac_accum.md
Name: neuron_mac_accum

Overview:
- Upstream stage of the sigmoid activation unit (sigmoid_approx) in a neuron datapath.
- Streams num_inputs (activation, weight) FP pairs and accumulates their products in FP. Uses the codebase's combinational multiplier and add_sub units.
- Presents the sum to sigmoid_approx on x_out and holds it stable until the activation result returns, then captures that result and hands it downstream.
- Also works around the sigmoid unit's change-detect trigger: a repeated sum would never restart the sigmoid, so the block caches the previous result.

Parameters:
- exp_width, 8, FP exponent width.
- mant_width, 24, FP mantissa width including hidden bit; word width W = exp_width+mant_width.
- num_inputs, 4, number of pairs per neuron evaluation; must be >= 1.
- cnt_width, 8, pair counter width; must hold num_inputs.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- round_mode, input, 3, rounding mode forwarded to the multiplier and add_sub.
- start, input, 1, pulse in IDLE begins an evaluation.
- in_valid, input, 1, pair valid.
- in_ready, output, 1, pair accepted when in_valid && in_ready.
- in_a, input, W, activation operand.
- in_w, input, W, weight operand.
- bias, input, W, bias value; used only with the optional feature.
- x_out, output, W, sum presented to sigmoid_approx.in_x.
- act_in, input, W, from sigmoid_approx.out_sigmoid.
- act_valid, input, 1, from sigmoid_approx.out_valid.
- result, output, W, captured activation.
- result_valid, output, 1, one-cycle pulse when result updates.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high) values:
  - state=IDLE; acc=0; cnt=0.
  - x_out=32'h00000000; result=0; result_valid=0; in_ready=0; busy=0.
  - Cache: last_x=0, last_act=32'h3f000000 (sigmoid(0)=0.5).
  - The reset cache matches sigmoid_approx, whose change detector also resets to 0.
- IDLE:
  - start=1 -> ACCUM.
  - acc is loaded with 0, or with bias when the optional feature is compiled in; cnt=0.
  - start is ignored in all other states.
- ACCUM:
  - in_ready=1.
  - On each accepted pair: acc <= acc + in_a*in_w, one pair per cycle. The multiplier and add_sub are cascaded combinationally and registered into acc. cnt increments.
  - Bubbles (in_valid=0) hold acc and cnt.
  - On acceptance of pair number num_inputs -> LOAD. in_ready drops in the following cycle.
- LOAD (1 cycle):
  - x_out <= acc.
  - If acc == last_x (bitwise): result <= last_act, result_valid pulses next cycle, -> IDLE. No sigmoid wait.
  - Otherwise -> WAIT, clearing a 1-bit arm flag.
- WAIT:
  - x_out is held constant.
  - act_valid is ignored in the first WAIT cycle (arm flag set at the end of that cycle). This rejects a stale out_valid left over from the previous computation.
  - act_valid=1 while armed: result <= act_in, last_x <= x_out, last_act <= act_in, result_valid=1 for exactly one cycle, -> IDLE.
- x_out keeps its last value in IDLE/ACCUM and changes only in LOAD. This guarantees sigmoid_approx sees a single transition per evaluation.
- FP exceptions from the arithmetic units are left unconnected. NaN/Inf sums propagate unchanged.
- Reset asserted mid-ACCUM or mid-WAIT returns all state to the reset values above. In particular, the cache is invalidated back to (0, 0.5).
- Latency from start (with one pair per cycle, no bubbles): num_inputs+1 cycles to LOAD, plus sigmoid latency plus 2 cycles to result_valid. On a cache hit, result_valid asserts 2 cycles after the last pair.

Optional Feature:
- Macro: NEURON_MAC_BIAS_EN.
- Defined: acc initialises to the bias input sampled at start.
- Undefined: acc initialises to +0.0 and the bias port is unused (tie off).

Test Plan:
- Reset, then check outputs → x_out=0, result=0, result_valid=0, busy=0, in_ready=0.
- Bias disabled; pairs a={3f800000,40000000,40400000,40800000}, w=3f000000 each, no bubbles → x_out=40a00000 (5.0) in LOAD. Model act_valid after 10 cycles with act_in=3f7ee8b5 → result=3f7ee8b5, one-cycle result_valid.
- Same stimulus with NEURON_MAC_BIAS_EN and bias=3f800000 → x_out=40c00000 (6.0).
- Repeat the 5.0 evaluation immediately → cache hit: no WAIT, result=3f7ee8b5 two cycles after the last pair, x_out unchanged.
- All inputs 0 → sum 0 hits the reset cache; result=3f000000 without waiting on act_valid. Separately, drive act_valid high during the first WAIT cycle → ignored; the next pulse is captured.
- Insert in_valid bubbles and assert rst mid-WAIT → acc unchanged across bubbles; after rst, state=IDLE, cache=(0, 3f000000), no result_valid.
